// File: rtl/pipe_fixed_point_sub.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fixed_point_sub
//  Brief    : Three-stage elastic signed fixed-point subtractor (out = ina - inb)
//             with per-operand Q formats, rounding and saturation.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_fixed_point_sub #(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIIA+WIFA-1:0] ina,
    input  logic [WIIB+WIFB-1:0] inb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow
);

    localparam int c_wii  = (WIIA > WIIB) ? WIIA : WIIB;
    localparam int c_wif  = (WIFA > WIFB) ? WIFA : WIFB;
    localparam int c_wi   = c_wii + c_wif;
    localparam int c_wr   = c_wi + 1;
    localparam int c_wo   = WOI + WOF;
    localparam int c_pad  = (WOF >= c_wif) ? (WOF - c_wif) : 0;
    localparam int c_drop = (WOF <  c_wif) ? (c_wif - WOF) : 0;
    // Zoomed value keeps one spare bit for the rounding carry and is always
    // wider than the output so the range compare is exact.
    localparam int c_wz   = ((c_wr + c_pad + 1) > (c_wo + 1)) ? (c_wr + c_pad + 1) : (c_wo + 1);

    localparam logic signed [c_wz-1:0] c_max = {{(c_wz-c_wo+1){1'b0}}, {(c_wo-1){1'b1}}};
    localparam logic signed [c_wz-1:0] c_min = {{(c_wz-c_wo+1){1'b1}}, {(c_wo-1){1'b0}}};

    logic                   r_v1, r_v2, r_v3;
    logic signed [c_wi-1:0] r_a1, r_b1;
    logic signed [c_wr-1:0] r_r2;
    logic [c_wo-1:0]        r_out;
    logic                   r_up, r_dn;

    logic                   w_rdy1, w_rdy2, w_rdy3;
    logic signed [c_wi-1:0] w_a_al, w_b_al;
    logic signed [c_wr-1:0] w_r;
    logic signed [c_wz-1:0] w_z;
    logic                   w_up, w_dn;
    logic [c_wo-1:0]        w_out;

    // Ready chain: a stage may load when empty or when its successor drains it.
    assign w_rdy3   = !r_v3 || out_ready;
    assign w_rdy2   = !r_v2 || w_rdy3;
    assign w_rdy1   = !r_v1 || w_rdy2;
    assign in_ready = w_rdy1 && !rst;

    assign w_a_al = c_wi'($signed(ina)) <<< (c_wif - WIFA);
    assign w_b_al = c_wi'($signed(inb)) <<< (c_wif - WIFB);

    assign w_r = c_wr'(r_a1) - c_wr'(r_b1);

    generate
        if (c_drop == 0) begin : g_pad
            assign w_z = c_wz'(r_r2) <<< c_pad;
        end else begin : g_drop
            logic signed [c_wz-1:0] w_q;
            logic signed [c_wz-1:0] w_inc;
            assign w_q   = c_wz'(r_r2) >>> c_drop;
            assign w_inc = {{(c_wz-1){1'b0}}, r_r2[c_drop-1]};
            assign w_z   = w_q + ((ROUND != 0) ? w_inc : '0);
        end
    endgenerate

    assign w_up  = (w_z > c_max);
    assign w_dn  = (w_z < c_min);
    assign w_out = ((ROOF != 0) && w_up) ? c_max[c_wo-1:0] :
                   ((ROOF != 0) && w_dn) ? c_min[c_wo-1:0] :
                   w_z[c_wo-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_a1  <= '0;
            r_b1  <= '0;
            r_r2  <= '0;
            r_out <= '0;
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
        end else begin
            if (w_rdy1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_a1 <= w_a_al;
                    r_b1 <= w_b_al;
                end
            end
            if (w_rdy2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_r2 <= w_r;
                end
            end
            if (w_rdy3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_out <= w_out;
                    r_up  <= w_up;
                    r_dn  <= w_dn;
                end
            end
        end
    end

    assign out_valid = r_v3;
    assign out       = r_out;
    assign upflow    = r_up;
    assign downflow  = r_dn;

endmodule
`default_nettype wire
